// File: rtl/seq_playback_ctrl.sv
// seq_playback_ctrl: plays pattern-ROM address ranges described by tag-list
// entries, stepping through entries on push-button requests.
// Ports: clk_1KHz/reset (sync, active-high); pb_seq_up/pb_seq_dn requests;
//   tag_addr/tag_data tag-list RAM (1-cycle registered read);
//   rom_addr/rom_en playback address; cur_seq, seq_changed, seq_wrap status.
// Option: define SEQ_PB_EDGE_EN to treat the buttons as levels and act on
//   rising edges only; otherwise each high cycle in PLAY is a request.
module seq_playback_ctrl #(
    parameter int START_DELAY = 32,
    parameter int TAG_AW      = 6,
    parameter int ROM_AW      = 10
) (
    input  logic              clk_1KHz,
    input  logic              reset,
    input  logic              pb_seq_up,
    input  logic              pb_seq_dn,
    output logic [TAG_AW-1:0] tag_addr,
    input  logic [27:0]       tag_data,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_en,
    output logic [6:0]        cur_seq,
    output logic              seq_changed,
    output logic              seq_wrap
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY} state_t;

    localparam int CW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(START_DELAY - 1);

    state_t state_q, state_d;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TAG_AW-1:0] idx_q, idx_d;
    logic [TAG_AW-1:0] last_idx_q, last_idx_d;
    logic [ROM_AW-1:0] start_q, start_d;
    logic [ROM_AW-1:0] end_q, end_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic [6:0]        seq_q, seq_d;
    logic              last_q, last_d;
    logic              en_q, en_d;
    logic              chg_q, chg_d;
    logic              wrap_q, wrap_d;

    logic              req_up, req_dn, req;

    logic [6:0]        t_seq;
    logic [ROM_AW-1:0] t_start, t_end;
    logic              t_last;

    assign t_seq   = tag_data[27:21];
    assign t_start = tag_data[2*ROM_AW:ROM_AW+1];
    assign t_end   = tag_data[ROM_AW:1];
    assign t_last  = tag_data[0];

`ifdef SEQ_PB_EDGE_EN
    logic up_prev_q, dn_prev_q;

    always_ff @(posedge clk_1KHz) begin
        if (reset) begin
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
        end else begin
            up_prev_q <= pb_seq_up;
            dn_prev_q <= pb_seq_dn;
        end
    end

    assign req_up = pb_seq_up & ~up_prev_q;
    assign req_dn = pb_seq_dn & ~dn_prev_q;
`else
    assign req_up = pb_seq_up;
    assign req_dn = pb_seq_dn;
`endif

    // Simultaneous up and down cancel out; only PLAY listens.
    assign req = (state_q == S_PLAY) && (req_up ^ req_dn);

    always_ff @(posedge clk_1KHz) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (cnt_q == CNT_LAST) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_PLAY;
            S_PLAY:  if (req) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        start_d    = start_q;
        end_d      = end_q;
        addr_d     = addr_q;
        seq_d      = seq_q;
        last_d     = last_q;
        en_d       = en_q;
        chg_d      = 1'b0;
        wrap_d     = 1'b0;
        unique case (state_q)
            S_IDLE: cnt_d = cnt_q + 1'b1;
            S_FETCH: ;
            S_WAIT: begin
                start_d = t_start;
                end_d   = t_end;
                last_d  = t_last;
                seq_d   = t_seq;
                addr_d  = t_start;
                en_d    = 1'b1;
                chg_d   = 1'b1;
                if (t_last) last_idx_d = idx_q;
            end
            S_PLAY: begin
                if (req) begin
                    en_d = 1'b0;
                    if (req_up)
                        idx_d = last_q ? '0 : idx_q + 1'b1;
                    else
                        idx_d = (idx_q == '0) ? last_idx_q : idx_q - 1'b1;
                end else if (end_q < start_q) begin
                    // Inverted range: park on start, never wrap.
                    addr_d = start_q;
                end else if (addr_q == end_q) begin
                    addr_d = start_q;
                    wrap_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_1KHz) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            start_q    <= '0;
            end_q      <= '0;
            addr_q     <= '0;
            seq_q      <= '0;
            last_q     <= 1'b0;
            en_q       <= 1'b0;
            chg_q      <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            start_q    <= start_d;
            end_q      <= end_d;
            addr_q     <= addr_d;
            seq_q      <= seq_d;
            last_q     <= last_d;
            en_q       <= en_d;
            chg_q      <= chg_d;
            wrap_q     <= wrap_d;
        end
    end

    assign tag_addr    = idx_q;
    assign rom_addr    = addr_q;
    assign rom_en      = en_q;
    assign cur_seq     = seq_q;
    assign seq_changed = chg_q;
    assign seq_wrap    = wrap_q;

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// tb_seq_playback_ctrl: randomized bench for seq_playback_ctrl with a
// tag-list RAM model and an arithmetic playback reference model.
module tb_seq_playback_ctrl;

    localparam int SD  = 32;
    localparam int TAW = 6;
    localparam int RAW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset = 1'b0;
    logic           up = 1'b0;
    logic           dn = 1'b0;
    logic [TAW-1:0] tag_addr;
    logic [27:0]    tag_data;
    logic [RAW-1:0] rom_addr;
    logic           rom_en;
    logic [6:0]     cur_seq;
    logic           seq_changed;
    logic           seq_wrap;

    logic [27:0] ram [64];

    always @(posedge clk) tag_data <= ram[tag_addr];

    seq_playback_ctrl #(
        .START_DELAY(SD),
        .TAG_AW     (TAW),
        .ROM_AW     (RAW)
    ) dut (
        .clk_1KHz   (clk),
        .reset      (reset),
        .pb_seq_up  (up),
        .pb_seq_dn  (dn),
        .tag_addr   (tag_addr),
        .tag_data   (tag_data),
        .rom_addr   (rom_addr),
        .rom_en     (rom_en),
        .cur_seq    (cur_seq),
        .seq_changed(seq_changed),
        .seq_wrap   (seq_wrap)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [27:0] ent(input int s, input int a,
                                        input int b, input bit l);
        return {7'(s), 10'(a), 10'(b), l};
    endfunction

    // Reference: cycles left until an entry plays, then a play-cycle count n.
    int m_wait = SD + 2;
    bit m_play = 0;
    bit m_loaded = 0;
    bit m_rst = 0;
    int m_idx = 0;
    int m_last_idx = 0;
    int m_seq = 0;
    int m_start = 0;
    int m_end = 0;
    bit m_last = 0;
    int m_n = 0;
    bit pu = 0;
    bit pd = 0;

    task automatic step(input logic u, input logic d, input logic r);
        bit ru, rd;
        logic [27:0] e;
        int len, ea;
        bit ew;
        up = u;
        dn = d;
        reset = r;
        @(posedge clk);
        #1;
`ifdef SEQ_PB_EDGE_EN
        ru = u && !pu;
        rd = d && !pd;
`else
        ru = u;
        rd = d;
`endif
        pu = r ? 1'b0 : u;
        pd = r ? 1'b0 : d;
        m_rst = 0;
        if (r) begin
            m_wait = SD + 2;
            m_play = 0;
            m_loaded = 0;
            m_idx = 0;
            m_last_idx = 0;
            m_seq = 0;
            m_rst = 1;
        end else if (!m_play) begin
            m_wait--;
            if (m_wait == 0) begin
                e = ram[m_idx];
                m_seq = int'(e[27:21]);
                m_start = int'(e[20:11]);
                m_end = int'(e[10:1]);
                m_last = e[0];
                if (m_last) m_last_idx = m_idx;
                m_n = 0;
                m_play = 1;
                m_loaded = 1;
            end
        end else if (ru != rd) begin
            m_play = 0;
            m_wait = 2;
            if (ru) m_idx = m_last ? 0 : (m_idx + 1) % 64;
            else    m_idx = (m_idx == 0) ? m_last_idx : m_idx - 1;
        end else begin
            m_n++;
        end

        chk("rom_en", 32'(rom_en), 32'(m_play));
        chk("tag_addr", 32'(tag_addr), 32'(m_idx));
        if (m_play || !m_loaded)
            chk("cur_seq", 32'(cur_seq), 32'(m_seq));
        if (m_play) begin
            if (m_end >= m_start) begin
                len = m_end - m_start + 1;
                ea = m_start + m_n % len;
                ew = (m_n > 0) && (m_n % len == 0);
            end else begin
                ea = m_start;
                ew = 0;
            end
            chk("rom_addr", 32'(rom_addr), 32'(ea));
            chk("seq_wrap", 32'(seq_wrap), 32'(ew));
            chk("seq_changed", 32'(seq_changed), 32'(m_n == 0));
        end else begin
            chk("seq_wrap_gap", 32'(seq_wrap), 32'(0));
            chk("seq_changed_gap", 32'(seq_changed), 32'(0));
            if (m_rst) chk("rom_addr_rst", 32'(rom_addr), 32'(0));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic rnd(input int n, input int pu_pct, input int pd_pct);
        logic u, d;
        for (int i = 0; i < n; i++) begin
            u = ($urandom_range(99) < pu_pct);
            d = ($urandom_range(99) < pd_pct);
            step(u, d, 1'b0);
        end
    endtask

    task automatic rand_table(input int last_at);
        int s, ln;
        for (int i = 0; i < 64; i++) begin
            s = $urandom_range(1000);
            ln = $urandom_range(12);
            ram[i] = ent($urandom_range(127), s, s + ln, (i == last_at));
        end
    endtask

    initial begin
        rand_table(-1);
        ram[0] = ent(1, 'h000, 'h005, 0);
        ram[1] = ent(2, 'h006, 'h00C, 0);
        ram[2] = ent(3, 'h00D, 'h015, 0);
        ram[3] = ent(4, 'h016, 'h02A, 0);
        ram[4] = ent(5, 'h02B, 'h03F, 1);

        step(1'b0, 1'b0, 1'b1);
        idle(60);
        repeat (5) begin
            step(1'b1, 1'b0, 1'b0);
            idle(100);
        end
        step(1'b0, 1'b1, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 1'b0);
        idle(10);
        step(1'b0, 1'b1, 1'b0);
        idle(10);
        step(1'b1, 1'b1, 1'b0);
        idle(10);
        repeat (50) step(1'b1, 1'b0, 1'b0);
        idle(20);
        rnd(1500, 4, 4);

        step(1'b0, 1'b0, 1'b1);
        idle(SD + 20);

        rand_table($urandom_range(3, 20));
        ram[0] = ent(9, 'h020, 'h024, 0);
        ram[1] = ent(7, 'h010, 'h008, 0);
        ram[2] = ent(8, 'h100, 'h100, 0);
        step(1'b0, 1'b0, 1'b1);
        idle(SD + 10);
        step(1'b1, 1'b0, 1'b0);
        idle(20);
        step(1'b1, 1'b0, 1'b0);
        idle(20);
        rnd(3000, 6, 6);

        rand_table(-1);
        step(1'b0, 1'b0, 1'b1);
        idle(SD + 5);
        step(1'b0, 1'b1, 1'b0);
        idle(10);
        rnd(4000, 25, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
